unsigned_sequential_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 17 +
 rtl/div_restore_step.sv | 26 ++
 rtl/unsigned_sequential_divider.sv | 156 +++++++++++++++
 tb/tb_unsigned_sequential_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential divider.
// FSM state encoding, default width and count-width helper.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring iteration: shift, trial subtract, restore.
// Purely combinational; instanced once by the divider top.
module div_restore_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One guard bit above the partial remainder carries the trial sign.
  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = shifted - {2'b00, divisor_i};
  assign qbit_o  = ~trial[WIDTH+1];
  assign rem_o   = qbit_o ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign q_o     = {q_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/unsigned_sequential_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// DIVIDER_ZERO_DETECT_EN short-circuits divide-by-zero to one cycle.
module unsigned_sequential_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;
  logic             step_qbit;

`ifdef DIVIDER_ZERO_DETECT_EN
  logic zero_q, zero_d;
  logic dbz_q, dbz_d;
`endif

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .q_i      (q_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q),
    .qbit_o   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
`ifdef DIVIDER_ZERO_DETECT_EN
    zero_d  = zero_q;
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      RUN: begin
`ifdef DIVIDER_ZERO_DETECT_EN
        if (zero_q) begin
          state_d = DONE;
          quo_d   = '1;
          rmd_d   = q_q;
          dbz_d   = 1'b1;
        end else begin
`else
        begin
`endif
          rem_d = step_rem;
          q_d   = step_q | {{(WIDTH-1){1'b0}}, step_qbit};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            quo_d   = q_d;
            rmd_d   = step_rem[WIDTH-1:0];
`ifdef DIVIDER_ZERO_DETECT_EN
            dbz_d   = 1'b0;
`endif
          end
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          dvs_d   = divisor;
          rem_d   = '0;
          q_d     = dividend;
          cnt_d   = '0;
`ifdef DIVIDER_ZERO_DETECT_EN
          zero_d  = (divisor == '0);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DIVIDER_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      dbz_q  <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_unsigned_sequential_divider.sv
// Self-checking bench for unsigned_sequential_divider.
// Directed cases plus random operands against a / and % model.
module tb_unsigned_sequential_divider;

  localparam int W = 32;
`ifdef DIVIDER_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tot = 0;
  int n_fail = 0;

  unsigned_sequential_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a,
                        input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Waits for done, then checks timing and results against plain / and %.
  task automatic finish_op(input string tag,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input int pre,
                           input bit chain,
                           input logic [W-1:0] na,
                           input logic [W-1:0] nb);
    int lat;
    int k;
    int nbsy;
    int bad;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [W-1:0] pq;
    logic [W-1:0] pr;
    lat  = (b == '0 && ZD) ? 1 : W;
    eq   = (b == '0) ? '1 : a / b;
    er   = (b == '0) ? a : a % b;
    k    = pre;
    nbsy = pre;
    bad  = 0;
    pq   = quotient;
    pr   = remainder;
    while (!done && k < W + 8) begin
      if (busy) nbsy++;
      if (quotient !== pq || remainder !== pr) bad++;
      step();
      k++;
    end
    chk({tag, ".lat"}, 64'(k), 64'(lat));
    chk({tag, ".busycyc"}, 64'(nbsy), 64'(lat));
    chk({tag, ".hold"}, 64'(bad), 64'd0);
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ZD && b == '0));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    if (chain) begin
      dividend = na;
      divisor  = nb;
      start    = 1'b1;
      step();
      start    = 1'b0;
      chk({tag, ".done_fall"}, 64'(done), 64'd0);
      chk({tag, ".chain_busy"}, 64'(busy), 64'd1);
    end else begin
      step();
      chk({tag, ".done_fall"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int extra;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) step();
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.q", 64'(quotient), 64'd0);
    chk("rst.r", 64'(remainder), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    step();

    launch(32'd100, 32'd7);
    chk("d100.busy", 64'(busy), 64'd1);
    finish_op("d100", 32'd100, 32'd7, 0, 1'b0, '0, '0);

    launch(32'hFFFF_FFFF, 32'd1);
    finish_op("dmax", 32'hFFFF_FFFF, 32'd1, 0, 1'b0, '0, '0);
    launch(32'd5, 32'd10);
    finish_op("d5", 32'd5, 32'd10, 0, 1'b0, '0, '0);

    launch(32'd1234, 32'd0);
    finish_op("dz", 32'd1234, 32'd0, 0, 1'b0, '0, '0);

    launch(32'd100, 32'd7);
    repeat (9) step();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    finish_op("ign", 32'd100, 32'd7, 10, 1'b0, '0, '0);
    extra = 0;
    repeat (40) begin
      if (done) extra++;
      step();
    end
    chk("ign.extra_done", 64'(extra), 64'd0);

    launch(32'd100, 32'd7);
    finish_op("b2b1", 32'd100, 32'd7, 0, 1'b1, 32'd50, 32'd6);
    finish_op("b2b2", 32'd50, 32'd6, 0, 1'b0, '0, '0);

    launch(32'hDEAD_BEEF, 32'h1234);
    repeat (16) step();
    rst = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.q", 64'(quotient), 64'd0);
    chk("arst.r", 64'(remainder), 64'd0);
    chk("arst.dbz", 64'(div_by_zero), 64'd0);
    step();
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      if (done || busy) extra++;
      step();
    end
    chk("arst.quiet", 64'(extra), 64'd0);
    launch(32'd100, 32'd7);
    finish_op("post", 32'd100, 32'd7, 0, 1'b0, '0, '0);

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) b = '0;
      else if (sel == 1) b = $urandom_range(1, 15);
      else b = $urandom;
      launch(a, b);
      finish_op($sformatf("rnd%0d", i), a, b, 0, 1'b0, '0, '0);
    end

    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

endmodule
